// File: rtl/id_decode_regfile.sv
// id_decode_regfile: RV32I instruction decode stage plus the 32x32 architectural register file.
//
// Decode outputs are purely combinational from inst_i. The register file is written on
// posedge clk and read combinationally. x0 always reads 0.
//
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write-back
// (wb_data) onto rs1_data/rs2_data when the addresses match. Without it, a read returns the
// stored value and the new value appears after the write edge.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   inst_i              fetched instruction word
//   wb_en/addr/data     write-back port (writes to x0 ignored)
//   rs1_data, rs2_data  read data for inst_i[19:15] / inst_i[24:20]
//   imm32               sign-extended immediate for the decoded format
//   rd_addr, funct3, funct7_5   raw instruction fields
//   alu_op, alu_src, branch, jump, mem_read, mem_write, mem_to_reg, reg_write   control
//   illegal             unsupported opcode (combinational)
//   illegal_seen        sticky flag, set on a clock edge while illegal is high
module id_decode_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_7FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm32,
  output logic [4:0]  rd_addr,
  output logic [2:0]  funct3,
  output logic        funct7_5,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic        branch,
  output logic        jump,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        illegal,
  output logic        illegal_seen
);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;

  logic [6:0]  opcode;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        writes_rd;

  assign opcode   = inst_i[6:0];
  assign rs1_addr = inst_i[19:15];
  assign rs2_addr = inst_i[24:20];
  assign rd_addr  = inst_i[11:7];
  assign funct3   = inst_i[14:12];
  assign funct7_5 = inst_i[30];

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    imm32      = '0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    writes_rd  = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OpR: begin
        alu_op    = 2'b10;
        writes_rd = 1'b1;
      end
      OpImm: begin
        alu_op    = 2'b11;
        alu_src   = 1'b1;
        imm32     = imm_i;
        writes_rd = 1'b1;
      end
      OpLoad: begin
        alu_src    = 1'b1;
        imm32      = imm_i;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        writes_rd  = 1'b1;
      end
      OpStore: begin
        alu_src   = 1'b1;
        imm32     = imm_s;
        mem_write = 1'b1;
      end
      OpBr: begin
        alu_op = 2'b01;
        imm32  = imm_b;
        branch = 1'b1;
      end
      OpJal: begin
        imm32     = imm_j;
        jump      = 1'b1;
        writes_rd = 1'b1;
      end
      OpJalr: begin
        alu_src   = 1'b1;
        imm32     = imm_i;
        jump      = 1'b1;
        writes_rd = 1'b1;
      end
      OpLui, OpAuipc: begin
        alu_src   = 1'b1;
        imm32     = imm_u;
        writes_rd = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // rd == x0 makes any writing instruction a no-op for the register file
  assign reg_write = writes_rd && (rd_addr != 5'd0);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        if (i == 2)      regs_q[i] <= SP_INIT;
        else if (i == 3) regs_q[i] <= GP_INIT;
        else             regs_q[i] <= '0;
      end
    end else if (wb_en && wb_addr != 5'd0) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         illegal_seen <= 1'b0;
    else if (illegal) illegal_seen <= 1'b1;
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = regs_q[rs1_addr];
`ifdef REGFILE_BYPASS_EN
      if (wb_en && wb_addr == rs1_addr) rs1_data = wb_data;
`endif
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      rs2_data = regs_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (wb_en && wb_addr == rs2_addr) rs2_data = wb_data;
`endif
    end
  end

endmodule

// File: tb/tb_id_decode_regfile.sv
module tb_id_decode_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] rs1_data, rs2_data, imm32;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [1:0]  alu_op;
  logic        alu_src, branch, jump, mem_read, mem_write, mem_to_reg, reg_write;
  logic        illegal, illegal_seen;

  always #5 clk = ~clk;

  id_decode_regfile dut (
    .clk(clk), .rst(rst), .inst_i(inst_i),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm32(imm32),
    .rd_addr(rd_addr), .funct3(funct3), .funct7_5(funct7_5),
    .alu_op(alu_op), .alu_src(alu_src), .branch(branch), .jump(jump),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal(illegal), .illegal_seen(illegal_seen)
  );

  localparam int SelRs1 = 0;
  localparam int SelRs2 = 1;
  localparam int SelImm = 2;
  localparam int SelCtl = 3;  // {alu_op, alu_src, branch, jump, mem_read, mem_write, mem_to_reg, reg_write, illegal}
  localparam int SelEn  = 4;  // {branch, jump, mem_read, mem_write, reg_write, illegal}
  localparam int SelSeen = 5;
  localparam int SelFld = 6;  // {rd_addr, funct3, funct7_5}

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [32];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        bypass_on;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SelRs1:  return rs1_data;
      SelRs2:  return rs2_data;
      SelImm:  return imm32;
      SelCtl:  return {22'd0, alu_op, alu_src, branch, jump, mem_read, mem_write, mem_to_reg,
                       reg_write, illegal};
      SelEn:   return {26'd0, branch, jump, mem_read, mem_write, reg_write, illegal};
      SelSeen: return {31'd0, illegal_seen};
      default: return {23'd0, rd_addr, funct3, funct7_5};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Compare everything queued against the settled DUT outputs
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl[2] = 32'h0000_7FFC;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, 5'd0, 7'b0110011};
  endfunction

  initial begin
`ifdef REGFILE_BYPASS_EN
    bypass_on = 1'b1;
`else
    bypass_on = 1'b0;
`endif
    rst = 1'b0;
    inst_i = rtype(5'd2, 5'd5);
    wb_en = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    push("rst_sp", SelRs1, 32'h0000_7FFC);
    push("rst_x5", SelRs2, 32'h0);
    push("rst_seen", SelSeen, 32'h0);
    drain();
    rst = 1'b1;

    // Write x5 then decode addi x6,x5,0
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    mdl[5] = 32'hDEAD_BEEF;
    @(negedge clk);
    wb_en = 1'b0;
    inst_i = 32'h0002_8313;
    #1;
    push("addi_rs1", SelRs1, 32'hDEAD_BEEF);
    push("addi_ctl", SelCtl, {22'd0, 10'b11_1_0_0_0_0_0_1_0});
    push("addi_imm", SelImm, 32'h0);
    push("addi_fld", SelFld, {23'd0, 5'd6, 3'd0, 1'b0});
    drain();

    // Write to x0 is ignored, including any forwarding
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    inst_i = rtype(5'd0, 5'd0);
    #1;
    push("x0_fwd", SelRs1, 32'h0);
    drain();
    @(negedge clk);
    wb_en = 1'b0;
    #1;
    push("x0_rs1", SelRs1, 32'h0);
    push("x0_rs2", SelRs2, 32'h0);
    drain();

    // beq x0,x0,-4
    @(negedge clk);
    inst_i = 32'hFE00_0EE3;
    #1;
    push("beq_ctl", SelCtl, {22'd0, 10'b01_0_1_0_0_0_0_0_0});
    push("beq_imm", SelImm, 32'hFFFF_FFFC);
    drain();

    // Same-cycle write/read of x7
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234_5678;
    inst_i = rtype(5'd7, 5'd7);
    #1;
    push("byp_rs1", SelRs1, bypass_on ? 32'h1234_5678 : 32'h0);
    push("byp_rs2", SelRs2, bypass_on ? 32'h1234_5678 : 32'h0);
    drain();
    mdl[7] = 32'h1234_5678;
    @(negedge clk);
    wb_en = 1'b0;
    #1;
    push("x7_rs1", SelRs1, 32'h1234_5678);
    push("x7_rs2", SelRs2, 32'h1234_5678);
    drain();

    // sw x5,-8(x2)
    @(negedge clk);
    inst_i = 32'hFE51_2C23;
    #1;
    push("sw_ctl", SelCtl, {22'd0, 10'b00_1_0_0_0_1_0_0_0});
    push("sw_imm", SelImm, 32'hFFFF_FFF8);
    push("sw_rs1", SelRs1, 32'h0000_7FFC);
    push("sw_rs2", SelRs2, 32'hDEAD_BEEF);
    drain();

    // lw x0,4(x1): load with rd=x0 must not write
    @(negedge clk);
    inst_i = 32'h0040_A003;
    #1;
    push("lw0_ctl", SelCtl, {22'd0, 10'b00_1_0_0_1_0_1_0_0});
    push("lw0_imm", SelImm, 32'h4);
    drain();

    // lui x1,0x12345 and jal x1,+8
    @(negedge clk);
    inst_i = 32'h1234_50B7;
    #1;
    push("lui_imm", SelImm, 32'h1234_5000);
    push("lui_en", SelEn, {26'd0, 6'b000010});
    drain();
    @(negedge clk);
    inst_i = 32'h0080_00EF;
    #1;
    push("jal_imm", SelImm, 32'h8);
    push("jal_en", SelEn, {26'd0, 6'b010010});
    drain();

    // add x3,x1,x2 with funct7 bit 30 set (sub)
    @(negedge clk);
    inst_i = 32'h4020_81B3;
    #1;
    push("sub_ctl", SelCtl, {22'd0, 10'b10_0_0_0_0_0_0_1_0});
    push("sub_imm", SelImm, 32'h0);
    push("sub_fld", SelFld, {23'd0, 5'd3, 3'd0, 1'b1});
    push("sub_rs2", SelRs2, 32'h0000_7FFC);
    drain();

    // Random write/read-back against the model
    for (int it = 0; it < 16; it++) begin
      logic [4:0]  a, b;
      logic [31:0] d;
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      d = $urandom;
      @(negedge clk);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
      if (a != 5'd0) mdl[a] = d;
      @(negedge clk);
      wb_en = 1'b0;
      inst_i = rtype(a, b);
      #1;
      push($sformatf("rnd%0d_rs1_x%0d", it, a), SelRs1, mdl[a]);
      push($sformatf("rnd%0d_rs2_x%0d", it, b), SelRs2, mdl[b]);
      drain();
    end

    // Illegal opcode and sticky flag
    @(negedge clk);
    inst_i = 32'h0000_007F;
    #1;
    push("ill_en", SelEn, {26'd0, 6'b000001});
    push("ill_imm", SelImm, 32'h0);
    push("ill_seen_pre", SelSeen, 32'h0);
    drain();
    @(negedge clk);
    inst_i = 32'h0002_8313;
    #1;
    push("ill_seen_set", SelSeen, 32'h1);
    push("legal_en", SelEn, {26'd0, 6'b000010});
    drain();
    repeat (2) @(negedge clk);
    #1;
    push("ill_seen_hold", SelSeen, 32'h1);
    drain();

    // Mid-cycle asynchronous reset
    @(negedge clk);
    inst_i = rtype(5'd5, 5'd2);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    push("arst_x5", SelRs1, 32'h0);
    push("arst_sp", SelRs2, 32'h0000_7FFC);
    push("arst_seen", SelSeen, 32'h0);
    drain();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    push("post_rst_x7", SelRs1, 32'h0);
    inst_i = rtype(5'd7, 5'd3);
    #1;
    push("post_rst_x7b", SelRs1, mdl[7]);
    push("post_rst_gp", SelRs2, 32'h0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
